rx_frame_writer: RTL and testbench
==================================

Name: rx_frame_writer

Overview:
Downstream consumer of the PC receive path. It pops decoded 32-bit payload words from the receive FIFO and presents them on a valid/ready write port with a sequential word address, intended for the frame/line store. It tracks packet boundaries using the decoder's fully-decoded pulse and reports frame completion, word count and overflow to the data manager.

Parameters:
ADDR_WIDTH, 16, width of o_wr_addr and o_word_count.
MAX_WORDS, 1024, maximum payload words accepted per frame; must be ≤ 2^ADDR_WIDTH.

Ports:
i_clock  in  1  system clock (50 MHz)
i_reset_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous flush, driven from the PC reset-all request
i_fifo_empty  in  1  receive FIFO empty flag
o_fifo_rdreq  out  1  FIFO read request, 1-cycle pulse per pop
i_fifo_q  in  32  FIFO output word, valid the cycle after the rdreq edge (non-showahead)
i_packet_fully_decoded  in  1  1-cycle pulse from the packet decoder
i_packet_command  in  1  packet command bit from the decoder
o_wr_valid  out  1  write word valid
i_wr_ready  in  1  write sink ready
o_wr_addr  out  ADDR_WIDTH  word address within the frame
o_wr_data  out  32  write word
o_frame_done  out  1  1-cycle pulse at end of frame
o_frame_command  out  1  command latched at o_frame_done
o_word_count  out  ADDR_WIDTH  words written in the last completed frame
o_overflow  out  1  sticky: a frame exceeded MAX_WORDS

Behaviour:
- Async reset (i_reset_n=0): state IDLE. All outputs are 0, including o_wr_data, o_wr_addr and o_word_count. The internal address, end_pending flag and end_age flag are all cleared.
- All outputs are registered.
- FSM states: IDLE, READ, WAIT, HOLD, DONE.
- IDLE:
  - If i_fifo_empty=0, go to READ and set o_fifo_rdreq=1 for exactly one cycle.
  - Otherwise, if the end condition holds, go to DONE.
- READ: deassert o_fifo_rdreq. Go to WAIT.
- WAIT:
  - If address < MAX_WORDS: capture i_fifo_q into o_wr_data, set o_wr_valid=1, go to HOLD.
  - Otherwise: discard the word, set o_overflow=1, go to IDLE.
- HOLD:
  - o_wr_valid, o_wr_data and o_wr_addr stay stable until i_wr_ready=1 at a clock edge.
  - On that transfer edge: clear o_wr_valid and increment the address.
  - Next state is READ with rdreq asserted if i_fifo_empty=0. Otherwise next state is IDLE.
- Latency: from the first edge sampling i_fifo_empty=0 in IDLE, o_wr_valid rises 2 edges later. Sustained throughput is 1 word per 3 cycles with i_wr_ready held high.
- End tracking:
  - i_packet_fully_decoded sets end_pending (any state) and clears end_age.
  - While end_pending=1, end_age sets on the following edge.
  - End condition: state IDLE, end_pending=1, end_age=1, i_fifo_empty=1. The age guard covers FIFO empty-flag lag when the last write and the decode pulse coincide.
- DONE (one cycle):
  - o_frame_done=1.
  - o_word_count = address, saturating at MAX_WORDS.
  - o_frame_command = i_packet_command.
  - Clear address, end_pending and end_age. Go to IDLE.
  - o_overflow is cleared on the first word accepted into the next frame, so software can read it with the done pulse.
- Decode pulse arriving while state is DONE: it is re-latched and belongs to the next frame.
- Address arithmetic: unsigned, ADDR_WIDTH bits. It never wraps, because words at or beyond MAX_WORDS are dropped.
- i_flush=1 (highest priority after reset):
  - Next state is IDLE. Clear address, end_pending, end_age, o_overflow and o_wr_valid.
  - The held word is dropped and o_fifo_rdreq is forced to 0.
  - o_word_count and o_frame_command are retained.
  - The FIFO is not drained by this block.
- Write sink never ready: the FSM stays in HOLD indefinitely. The FIFO fills and upstream drops data; this is acceptable.
- Empty FIFO is never read. o_fifo_rdreq is only issued when i_fifo_empty=0 was sampled on the same edge.

Decomposition:
- Shared package rx_path_pkg holds:
  - the FSM state enum (IDLE, READ, WAIT, HOLD, DONE);
  - RX_WORD_WIDTH=32;
  - the default MAX_WORDS constant.
- No sub-module is needed. The FSM, address counter and end tracker live in one module.

Test Plan:
- 3 words preloaded, i_wr_ready=1, then a decode pulse → writes addr 0,1,2 with correct data; o_frame_done 1 cycle; o_word_count=3; exactly 3 rdreq pulses.
- i_wr_ready low 10 cycles while holding word 0xDEADBEEF → o_wr_valid, data and addr stable; transfers on the first ready edge; addr becomes 1.
- Last FIFO write and i_packet_fully_decoded on the same cycle, with 1-cycle empty-flag lag → the last word is written before o_frame_done; word_count includes it.
- MAX_WORDS=4, push 6 words plus decode pulse → addr 0..3 written; 2 words popped and discarded; o_overflow=1; o_word_count=4; overflow clears on the next frame's first word.
- i_flush asserted while in HOLD at addr 5 → o_wr_valid drops the next cycle; addr returns to 0; no o_frame_done; next frame starts at addr 0.
- i_reset_n asserted mid-WAIT, asynchronously → all outputs 0 immediately with no clock; the FSM resumes in IDLE after release.

Source files
------------

// File: rtl/rx_path_pkg.sv
// rtl/rx_path_pkg.sv - shared types and constants for the PC receive path
// Contents:
//   rx_state_t        frame writer FSM states
//   RX_WORD_WIDTH     payload word width
//   DEFAULT_MAX_WORDS default per-frame word limit
package rx_path_pkg;

  localparam int RX_WORD_WIDTH     = 32;
  localparam int DEFAULT_MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } rx_state_t;

endpackage

// File: rtl/rx_frame_writer.sv
// rtl/rx_frame_writer.sv - pops receive FIFO words into an addressed frame write port
// Ports:
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   i_flush                   synchronous flush (PC reset-all)
//   i_fifo_empty, o_fifo_rdreq, i_fifo_q
//                             non-showahead receive FIFO read side
//   i_packet_fully_decoded, i_packet_command
//                             end-of-packet pulse and command bit from the decoder
//   o_wr_valid, i_wr_ready, o_wr_addr, o_wr_data
//                             valid/ready word write port to the frame store
//   o_frame_done, o_frame_command, o_word_count, o_overflow
//                             frame completion status to the data manager
module rx_frame_writer
  import rx_path_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WORDS  = DEFAULT_MAX_WORDS
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_flush,
  input  logic                     i_fifo_empty,
  output logic                     o_fifo_rdreq,
  input  logic [RX_WORD_WIDTH-1:0] i_fifo_q,
  input  logic                     i_packet_fully_decoded,
  input  logic                     i_packet_command,
  output logic                     o_wr_valid,
  input  logic                     i_wr_ready,
  output logic [ADDR_WIDTH-1:0]    o_wr_addr,
  output logic [RX_WORD_WIDTH-1:0] o_wr_data,
  output logic                     o_frame_done,
  output logic                     o_frame_command,
  output logic [ADDR_WIDTH-1:0]    o_word_count,
  output logic                     o_overflow
);

  // One extra address bit so a limit of 2^ADDR_WIDTH can be reached without wrapping.
  localparam logic [ADDR_WIDTH:0] MAX_W = (ADDR_WIDTH + 1)'(MAX_WORDS);

  rx_state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]      addr_q, addr_d;
  logic                     end_pending_q, end_pending_d;
  logic                     end_age_q, end_age_d;
  logic                     rdreq_q, rdreq_d;
  logic                     wr_valid_q, wr_valid_d;
  logic [RX_WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                     frame_done_q, frame_done_d;
  logic                     frame_cmd_q, frame_cmd_d;
  logic [ADDR_WIDTH-1:0]    word_count_q, word_count_d;
  logic                     overflow_q, overflow_d;
  logic [ADDR_WIDTH:0]      addr_sat;

  assign addr_sat = (addr_q > MAX_W) ? MAX_W : addr_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      end_pending_q <= 1'b0;
      end_age_q     <= 1'b0;
      rdreq_q       <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_cmd_q   <= 1'b0;
      word_count_q  <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      end_pending_q <= end_pending_d;
      end_age_q     <= end_age_d;
      rdreq_q       <= rdreq_d;
      wr_valid_q    <= wr_valid_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_cmd_q   <= frame_cmd_d;
      word_count_q  <= word_count_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rdreq_d       = 1'b0;
    wr_valid_d    = wr_valid_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_cmd_d   = frame_cmd_q;
    word_count_d  = word_count_q;
    overflow_d    = overflow_q;
    end_pending_d = end_pending_q;
    // end_age marks that the decode pulse is at least one edge old, which lets a
    // lagging FIFO empty flag catch up with a word written alongside the pulse.
    end_age_d     = end_age_q | end_pending_q;

    case (state_q)
      ST_IDLE: begin
        if (!i_fifo_empty) begin
          state_d = ST_READ;
          rdreq_d = 1'b1;
        end else if (end_pending_q && end_age_q) begin
          // Status is registered on entry so the done pulse and its status align.
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
          word_count_d = addr_sat[ADDR_WIDTH-1:0];
          frame_cmd_d  = i_packet_command;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (addr_q < MAX_W) begin
          wr_data_d  = i_fifo_q;
          wr_valid_d = 1'b1;
          state_d    = ST_HOLD;
          // Overflow stays visible through the done pulse and drops with the next frame's first word.
          if (addr_q == '0) overflow_d = 1'b0;
        end else begin
          overflow_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (i_wr_ready) begin
          wr_valid_d = 1'b0;
          addr_d     = addr_q + 1'b1;
          if (!i_fifo_empty) begin
            state_d = ST_READ;
            rdreq_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        addr_d        = '0;
        end_pending_d = 1'b0;
        end_age_d     = 1'b0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A decode pulse in DONE wins over the clear and belongs to the next frame.
    if (i_packet_fully_decoded) begin
      end_pending_d = 1'b1;
      end_age_d     = 1'b0;
    end

    if (i_flush) begin
      state_d       = ST_IDLE;
      addr_d        = '0;
      end_pending_d = 1'b0;
      end_age_d     = 1'b0;
      overflow_d    = 1'b0;
      wr_valid_d    = 1'b0;
      rdreq_d       = 1'b0;
      frame_done_d  = 1'b0;
      frame_cmd_d   = frame_cmd_q;
      word_count_d  = word_count_q;
    end
  end

  assign o_fifo_rdreq    = rdreq_q;
  assign o_wr_valid      = wr_valid_q;
  assign o_wr_addr       = addr_q[ADDR_WIDTH-1:0];
  assign o_wr_data       = wr_data_q;
  assign o_frame_done    = frame_done_q;
  assign o_frame_command = frame_cmd_q;
  assign o_word_count    = word_count_q;
  assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_rx_frame_writer.sv
// tb/tb_rx_frame_writer.sv - directed self-checking bench for rx_frame_writer
// Instances: dut_a (default limits, optional empty-flag lag), dut_b (MAX_WORDS=4).
module tb_rx_frame_writer;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, flush, decoded, cmd, ready;

  logic        a_empty, a_rdreq, a_valid, a_done, a_fcmd, a_ovf;
  logic [15:0] a_addr, a_cnt;
  logic [31:0] a_q = '0, a_data, a_pd;
  logic        a_push, a_lag;
  logic [31:0] a_mem[$];
  int          a_fcnt = 0;
  bit          a_fresh = 1'b0;

  logic        b_empty, b_rdreq, b_valid, b_done, b_fcmd, b_ovf;
  logic [15:0] b_addr, b_cnt;
  logic [31:0] b_q = '0, b_data, b_pd;
  logic        b_push;
  logic [31:0] b_mem[$];
  int          b_fcnt = 0;

  int          vectors = 0, miscompares = 0;

  logic [15:0] a_log_addr[$], b_log_addr[$];
  logic [31:0] a_log_data[$], b_log_data[$];
  int          a_rd_cnt = 0, a_done_cnt = 0, b_rd_cnt = 0;

  rx_frame_writer dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_fifo_empty(a_empty), .o_fifo_rdreq(a_rdreq), .i_fifo_q(a_q),
    .i_packet_fully_decoded(decoded), .i_packet_command(cmd),
    .o_wr_valid(a_valid), .i_wr_ready(ready), .o_wr_addr(a_addr), .o_wr_data(a_data),
    .o_frame_done(a_done), .o_frame_command(a_fcmd), .o_word_count(a_cnt), .o_overflow(a_ovf)
  );

  rx_frame_writer #(.ADDR_WIDTH(16), .MAX_WORDS(4)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_fifo_empty(b_empty), .o_fifo_rdreq(b_rdreq), .i_fifo_q(b_q),
    .i_packet_fully_decoded(decoded), .i_packet_command(cmd),
    .o_wr_valid(b_valid), .i_wr_ready(ready), .o_wr_addr(b_addr), .o_wr_data(b_data),
    .o_frame_done(b_done), .o_frame_command(b_fcmd), .o_word_count(b_cnt), .o_overflow(b_ovf)
  );

  // Non-showahead FIFO models; a_lag hides a freshly written last word for one extra cycle.
  always @(posedge clk) begin
    if (a_rdreq && a_mem.size() > 0) a_q <= a_mem.pop_front();
    if (a_push) a_mem.push_back(a_pd);
    a_fcnt  <= a_mem.size();
    a_fresh <= a_push && a_lag;
  end
  assign a_empty = (a_fcnt == 0) || (a_fresh && a_fcnt == 1);

  always @(posedge clk) begin
    if (b_rdreq && b_mem.size() > 0) b_q <= b_mem.pop_front();
    if (b_push) b_mem.push_back(b_pd);
    b_fcnt <= b_mem.size();
  end
  assign b_empty = (b_fcnt == 0);

  always @(posedge clk) begin
    if (a_valid && ready) begin a_log_addr.push_back(a_addr); a_log_data.push_back(a_data); end
    if (b_valid && ready) begin b_log_addr.push_back(b_addr); b_log_data.push_back(b_data); end
    if (a_rdreq) a_rd_cnt++;
    if (a_done)  a_done_cnt++;
    if (b_rdreq) b_rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d);
    a_push = 1'b1; a_pd = d;
    @(negedge clk);
    a_push = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] d);
    b_push = 1'b1; b_pd = d;
    @(negedge clk);
    b_push = 1'b0;
  endtask

  task automatic pulse_decode(input logic c);
    decoded = 1'b1; cmd = c;
    @(negedge clk);
    decoded = 1'b0;
  endtask

  task automatic wait_a_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (a_log_addr.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_a_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_a_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_valid) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    int base, dbase, rbase;
    bit ok, stable;

    rst_n = 1'b1; flush = 1'b0; decoded = 1'b0; cmd = 1'b0; ready = 1'b0;
    a_push = 1'b0; a_pd = '0; a_lag = 1'b0; b_push = 1'b0; b_pd = '0;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_flags", {27'd0, a_rdreq, a_valid, a_done, a_fcmd, a_ovf}, 32'd0);
    chk("rst_addr", {16'd0, a_addr}, 32'd0);
    chk("rst_data", a_data, 32'd0);
    chk("rst_count", {16'd0, a_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-word frame with the sink always ready.
    ready = 1'b1;
    base = a_log_addr.size(); dbase = a_done_cnt; rbase = a_rd_cnt;
    push_a(32'hA000_0001);
    push_a(32'hA000_0002);
    push_a(32'hA000_0003);
    wait_a_log(base + 3, ok);
    chk("t1_writes_seen", {31'd0, ok}, 32'd1);
    pulse_decode(1'b1);
    wait_a_done(ok);
    chk("t1_done_seen", {31'd0, ok}, 32'd1);
    chk("t1_word_count", {16'd0, a_cnt}, 32'd3);
    chk("t1_frame_cmd", {31'd0, a_fcmd}, 32'd1);
    chk("t1_rdreq_pulses", a_rd_cnt - rbase, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", {16'd0, a_log_addr[base+i]}, i);
      chk("t1_data", a_log_data[base+i], 32'hA000_0001 + i);
    end
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, a_done}, 32'd0);
    chk("t1_done_count", a_done_cnt - dbase, 32'd1);

    // Back-pressure: sink not ready for 10 cycles while a word is held.
    ready = 1'b0;
    base = a_log_addr.size();
    push_a(32'hDEAD_BEEF);
    wait_a_valid(ok);
    chk("t2_valid_seen", {31'd0, ok}, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(a_valid === 1'b1 && a_data === 32'hDEAD_BEEF && a_addr === 16'd0)) stable = 1'b0;
      @(negedge clk);
    end
    chk("t2_hold_stable", {31'd0, stable}, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_dropped", {31'd0, a_valid}, 32'd0);
    chk("t2_addr_advanced", {16'd0, a_addr}, 32'd1);
    chk("t2_transfer_data", a_log_data[base], 32'hDEAD_BEEF);
    chk("t2_transfer_count", a_log_addr.size() - base, 32'd1);
    pulse_decode(1'b0);
    wait_a_done(ok);
    chk("t2_word_count", {16'd0, a_cnt}, 32'd1);
    chk("t2_frame_cmd", {31'd0, a_fcmd}, 32'd0);

    // Last word written with the decode pulse while the empty flag lags a cycle.
    a_lag = 1'b1;
    base = a_log_addr.size();
    push_a(32'h5000_0001);
    wait_a_log(base + 1, ok);
    repeat (3) @(negedge clk);
    a_push = 1'b1; a_pd = 32'h5000_0002; decoded = 1'b1; cmd = 1'b1;
    @(negedge clk);
    a_push = 1'b0; decoded = 1'b0;
    wait_a_done(ok);
    chk("t3_done_seen", {31'd0, ok}, 32'd1);
    chk("t3_words_before_done", a_log_addr.size() - base, 32'd2);
    chk("t3_last_data", a_log_data[base+1], 32'h5000_0002);
    chk("t3_last_addr", {16'd0, a_log_addr[base+1]}, 32'd1);
    chk("t3_word_count", {16'd0, a_cnt}, 32'd2);
    a_lag = 1'b0;
    @(negedge clk);

    // Flush while holding the word at address 5.
    base = a_log_addr.size(); dbase = a_done_cnt;
    for (int i = 0; i < 5; i++) push_a(32'hF000_0000 + i);
    wait_a_log(base + 5, ok);
    chk("t4_five_written", {31'd0, ok}, 32'd1);
    ready = 1'b0;
    push_a(32'hF000_0005);
    wait_a_valid(ok);
    chk("t4_hold_addr", {16'd0, a_addr}, 32'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_valid_dropped", {31'd0, a_valid}, 32'd0);
    chk("t4_addr_cleared", {16'd0, a_addr}, 32'd0);
    chk("t4_count_retained", {16'd0, a_cnt}, 32'd2);
    chk("t4_cmd_retained", {31'd0, a_fcmd}, 32'd1);
    ready = 1'b1;
    push_a(32'h7777_0001);
    wait_a_log(base + 6, ok);
    chk("t4_next_written", {31'd0, ok}, 32'd1);
    chk("t4_next_addr", {16'd0, a_log_addr[a_log_addr.size()-1]}, 32'd0);
    chk("t4_next_data", a_log_data[a_log_data.size()-1], 32'h7777_0001);
    chk("t4_no_done", a_done_cnt - dbase, 32'd0);

    // Overflow on the MAX_WORDS=4 instance: six words, two dropped.
    base = b_log_addr.size(); rbase = b_rd_cnt;
    for (int i = 0; i < 6; i++) push_b(32'hB000_0000 + i);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b_rd_cnt - rbase >= 6) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t5_all_popped", {31'd0, ok}, 32'd1);
    pulse_decode(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_done) begin ok = 1'b1; break; end
    end
    chk("t5_done_seen", {31'd0, ok}, 32'd1);
    chk("t5_word_count", {16'd0, b_cnt}, 32'd4);
    chk("t5_overflow_set", {31'd0, b_ovf}, 32'd1);
    chk("t5_rdreq_pulses", b_rd_cnt - rbase, 32'd6);
    chk("t5_words_written", b_log_addr.size() - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_addr", {16'd0, b_log_addr[base+i]}, i);
      chk("t5_data", b_log_data[base+i], 32'hB000_0000 + i);
    end
    push_b(32'hB100_0000);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_valid) begin ok = 1'b1; break; end
    end
    chk("t5_next_valid", {31'd0, ok}, 32'd1);
    chk("t5_overflow_cleared", {31'd0, b_ovf}, 32'd0);
    chk("t5_next_addr", {16'd0, b_addr}, 32'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset while dut_a is in WAIT.
    ready = 1'b0;
    push_a(32'h1234_5678);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (a_rdreq) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t6_rdreq_seen", {31'd0, ok}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_flags", {27'd0, a_rdreq, a_valid, a_done, a_fcmd, a_ovf}, 32'd0);
    chk("t6_rst_count", {16'd0, a_cnt}, 32'd0);
    chk("t6_rst_data", a_data, 32'd0);
    chk("t6_rst_addr", {16'd0, a_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    base = a_log_addr.size();
    push_a(32'h0BAD_F00D);
    wait_a_log(base + 1, ok);
    chk("t6_resume_written", {31'd0, ok}, 32'd1);
    chk("t6_resume_addr", {16'd0, a_log_addr[a_log_addr.size()-1]}, 32'd0);
    chk("t6_resume_data", a_log_data[a_log_data.size()-1], 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
